// File: rtl/axi_burst_master.sv
// AXI3-style burst initiator: one write (AW/W/B) or read (AR/R) burst per local command,
// with up-front legality checks, an idle watchdog and a worst-response completion report.
module axi_burst_master #(
  parameter logic [2:0]  AXSIZE  = 3'd2,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [3:0]  cmd_id,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [1:0]  cmd_burst,
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [31:0] wd_data,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic        done,
  output logic [1:0]  done_resp,
  output logic        done_err,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        wvalid,
  input  logic        wready,
  output logic        wlast,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic        rlast,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp
);

  localparam int              BYTES      = 1 << AXSIZE;
  localparam logic [31:0]     ALIGN_MASK = 32'(BYTES - 1);
  localparam logic [3:0]      STRB_ALL   = 4'((1 << BYTES) - 1);
  localparam int              WDW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]  WD_MAX     = WDW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, CHECK, WADDR, WDATA, WRESP, RADDR, RDATA, DONE} state_t;

  // A command is illegal for a reserved burst, misalignment, a bad WRAP length or an INCR 4KB crossing.
  function automatic logic check_reject(input logic [31:0] addr, input logic [3:0] len,
                                        input logic [1:0] burst);
    logic [12:0] span;
    logic        bad;
    span = {1'b0, addr[11:0]} + (({9'd0, len} + 13'd1) << AXSIZE);
    case (burst)
      2'b11:   bad = 1'b1;
      2'b10:   bad = !(len inside {4'd1, 4'd3, 4'd7, 4'd15});
      2'b01:   bad = (span > 13'd4096);
      default: bad = 1'b0;
    endcase
    return bad | ((addr & ALIGN_MASK) != 32'd0);
  endfunction

  state_t          state_q, state_d;
  logic            rdy_q;
  logic            wr_q;
  logic [3:0]      id_q, len_q;
  logic [31:0]     addr_q;
  logic [1:0]      burst_q;
  logic [3:0]      beat_q, beat_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic [1:0]      resp_q, resp_d;
  logic            err_q, err_d;
  logic            hs_s, active_s, timeout_s, cmd_hs_s, last_beat_s;

  assign cmd_hs_s    = (state_q == IDLE) && rdy_q && cmd_valid;
  assign active_s    = state_q inside {WADDR, WDATA, WRESP, RADDR, RDATA};
  assign timeout_s   = active_s && (wdog_q == WD_MAX);
  assign last_beat_s = (beat_q == len_q);
  assign done_resp   = resp_q;
  assign done_err    = err_q;

  // Control state, beat counter, watchdog and completion status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      beat_q  <= 4'd0;
      wdog_q  <= '0;
      resp_q  <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      beat_q  <= beat_d;
      wdog_q  <= wdog_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  // Command fields captured at the IDLE handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      id_q    <= 4'd0;
      addr_q  <= 32'd0;
      len_q   <= 4'd0;
      burst_q <= 2'b00;
    end else if (cmd_hs_s) begin
      wr_q    <= cmd_wr;
      id_q    <= cmd_id;
      addr_q  <= cmd_addr;
      len_q   <= cmd_len;
      burst_q <= cmd_burst;
    end
  end

  // Next-state and bus outputs; a watchdog expiry silences every handshake signal for that cycle
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    resp_d    = resp_q;
    err_d     = err_q;
    hs_s      = 1'b0;
    cmd_ready = 1'b0;
    wd_ready  = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = 32'd0;
    rd_last   = 1'b0;
    done      = 1'b0;
    awvalid   = 1'b0;
    awid      = 4'd0;
    awaddr    = 32'd0;
    awlen     = 4'd0;
    awsize    = 3'd0;
    awburst   = 2'b00;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    wid       = 4'd0;
    wdata     = 32'd0;
    wstrb     = 4'd0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    arid      = 4'd0;
    araddr    = 32'd0;
    arlen     = 4'd0;
    arsize    = 3'd0;
    arburst   = 2'b00;
    rready    = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = rdy_q;
        if (cmd_hs_s) state_d = CHECK;
        else          state_d = IDLE;
      end
      CHECK: begin
        resp_d = 2'b00;
        err_d  = check_reject(addr_q, len_q, burst_q);
        beat_d = 4'd0;
        if (err_d)     state_d = DONE;
        else if (wr_q) state_d = WADDR;
        else           state_d = RADDR;
      end
      WADDR: begin
        if (timeout_s) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          awvalid = 1'b1;
          awid    = id_q;
          awaddr  = addr_q;
          awlen   = len_q;
          awsize  = AXSIZE;
          awburst = burst_q;
          hs_s    = awready;
          if (awready) state_d = WDATA;
          else         state_d = WADDR;
        end
      end
      WDATA: begin
        if (timeout_s) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wvalid   = wd_valid;
          wd_ready = wready;
          wdata    = wd_data;
          wid      = id_q;
          wstrb    = STRB_ALL;
          wlast    = last_beat_s;
          hs_s     = wd_valid && wready;
          if (hs_s) begin
            beat_d = beat_q + 4'd1;
            if (last_beat_s) state_d = WRESP;
            else             state_d = WDATA;
          end else begin
            state_d = WDATA;
          end
        end
      end
      WRESP: begin
        if (timeout_s) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          bready = 1'b1;
          hs_s   = bvalid;
          if (bvalid) begin
            resp_d  = bresp;
            err_d   = err_q | (bid != id_q);
            state_d = DONE;
          end else begin
            state_d = WRESP;
          end
        end
      end
      RADDR: begin
        if (timeout_s) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          arvalid = 1'b1;
          arid    = id_q;
          araddr  = addr_q;
          arlen   = len_q;
          arsize  = AXSIZE;
          arburst = burst_q;
          hs_s    = arready;
          if (arready) state_d = RDATA;
          else         state_d = RADDR;
        end
      end
      RDATA: begin
        if (timeout_s) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          rready = 1'b1;
          hs_s   = rvalid;
          if (rvalid) begin
            rd_valid = 1'b1;
            rd_data  = rdata;
            rd_last  = rlast;
            beat_d   = beat_q + 4'd1;
            if (rresp > resp_q) resp_d = rresp;
            else                resp_d = resp_q;
            // rlast must coincide exactly with the final counted beat
            if ((rlast != last_beat_s) || (rid != id_q)) err_d = 1'b1;
            else                                         err_d = err_q;
            if (rlast || last_beat_s) state_d = DONE;
            else                      state_d = RDATA;
          end else begin
            state_d = RDATA;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!active_s || hs_s || (state_d != state_q)) wdog_d = '0;
    else                                           wdog_d = wdog_q + WDW'(1);
  end

endmodule
